alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one registered ALU (a/b 32b, op_code 5b, out 64b) between NUM_REQ requesters.
//  Round-robin grant, one operation in flight; valid/ready request channel in, per-requester
//  response out. Sits between the requester ports and the ALU enable/operand pins.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ALU_LAT  1  ALU cycles from sampled operands to valid out (1..4)
// PORTS
//  clk           in   1            rising-edge clock
//  rst           in   1            asynchronous, active-low reset
//  req_valid     in   NUM_REQ      per-requester request valid
//  req_ready     out  NUM_REQ      one-hot accept, only in IDLE
//  req_a         in   NUM_REQ*32   operand A, requester i at [32*i +: 32]
//  req_b         in   NUM_REQ*32   operand B, same packing
//  req_op        in   NUM_REQ*5    op_code, requester i at [5*i +: 5]
//  resp_valid    out  NUM_REQ      one-hot: response for granted requester
//  resp_ready    in   NUM_REQ      requester accepts response
//  resp_data     out  64           captured ALU result (shared bus)
//  resp_err      out  1            1 = illegal op_code, resp_data forced 0
//  alu_a/alu_b   out  32 each      registered operands to ALU
//  alu_op_code   out  5            registered op_code to ALU
//  alu_en        out  1            high only in EXEC
//  alu_out       in   64           ALU result
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; req_ready, resp_valid, resp_err, alu_en = 0;
//    resp_data, alu_a, alu_b, alu_op_code = 0; rr pointer = NUM_REQ-1 (req0 wins first).
//  - States IDLE -> EXEC -> RESP -> IDLE; illegal op: IDLE -> RESP directly.
//  - IDLE: winner g = first i with req_valid[i], searching from ptr+1 wrapping modulo
//    NUM_REQ. req_ready[g]=1 combinationally, others 0. Handshake on edge with
//    req_valid[g]&req_ready[g]: latch g, ptr<=g, load operands/op into alu_* regs.
//  - Legal op_codes: 00001 add, 00010 sub, 00011 mul, 00100 shl1, 00101 shr1, 00110 and,
//    00111 or, 01000 inc, 01010 dec. Any other value -> RESP with resp_err=1, data=0,
//    ALU untouched (alu_en stays 0, alu_* regs not updated).
//  - EXEC: alu_en=1; down-counter loaded with ALU_LAT at accept; alu_out captured into
//    resp_data on the edge where counter==0, i.e. ALU_LAT+1 edges after accept.
//    ALU_LAT=1: accept edge E0, capture E2, resp_valid high after E2.
//  - RESP: resp_valid[g]=1 and resp_data/resp_err stable until resp_valid[g]&resp_ready[g];
//    that edge -> IDLE, resp_valid cleared. resp_ready of other requesters ignored.
//  - No new request accepted outside IDLE; earliest next accept is cycle after RESP exit.
//  - req_valid drop before handshake: grant re-evaluated next cycle, no side effects.
//  - Reset mid-operation: in-flight op discarded, no response issued, ptr reset.
//  - resp_data/alu_* hold last values when idle; 64-bit result taken verbatim.
// TESTING
//  1. Reset: rst=0 with all req_valid=1 -> all outputs 0, no req_ready; release -> req0
//     granted first.
//  2. Single add: req1 a=5,b=7,op=00001 -> resp_valid[1] 2 cycles after accept,
//     resp_data=12, resp_err=0.
//  3. Round-robin: req0..3 valid continuously (op=00011, a=3,b=4) -> grant order 0,1,2,3,0;
//     each resp_data=12.
//  4. Illegal op: req2 op=01001 -> resp_valid[2] 1 cycle after accept, resp_err=1,
//     resp_data=0, alu_en never high.
//  5. Backpressure: resp_ready[0]=0 for 5 cycles after sub a=10,b=3 -> resp_valid[0] and
//     resp_data=7 held; req1 valid meanwhile gets no req_ready until resp taken.
//  6. Reset mid-EXEC: rst low during alu_en=1 -> no resp_valid; after release req0 granted.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NUM_REQ valid/ready requesters.
// One operation in flight at a time; illegal op_codes are answered with resp_err and no ALU use.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*5-1:0] req_op,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [63:0]          resp_data,
    output logic                 resp_err,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [4:0]           alu_op_code,
    output logic                 alu_en,
    input  logic [63:0]          alu_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [63:0]        r_resp_data;
    logic               r_resp_err;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [4:0]         r_alu_op;
    logic               r_alu_en;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_accept;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [4:0]         w_sel_op;
    logic               w_legal;

    // First valid requester after the pointer, wrapping around.
    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            v_idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[IDX_W'(v_idx)]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_sel_a  = req_a[32*i +: 32];
                w_sel_b  = req_b[32*i +: 32];
                w_sel_op = req_op[5*i +: 5];
            end
        end
    end

    always_comb begin
        case (w_sel_op)
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000, 5'b01010: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
    end

    // Grant is withheld while reset is asserted so no ready leaks out during reset.
    assign w_ready  = (rst && r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_win) : '0;
    assign w_accept = |(req_valid & w_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= IDX_W'(NUM_REQ - 1);
            r_gnt        <= '0;
            r_cnt        <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_en     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt <= w_win;
                        r_ptr <= w_win;
                        if (w_legal) begin
                            r_alu_a  <= w_sel_a;
                            r_alu_b  <= w_sel_b;
                            r_alu_op <= w_sel_op;
                            r_alu_en <= 1'b1;
                            r_cnt    <= CNT_W'(ALU_LAT);
                            r_state  <= S_EXEC;
                        end else begin
                            r_resp_err  <= 1'b1;
                            r_resp_data <= '0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_resp_data  <= alu_out;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= NUM_REQ'(1) << r_gnt;
                        r_alu_en     <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    // Illegal-op path enters here without a valid yet; raise it one cycle later.
                    if (r_resp_valid == '0) begin
                        r_resp_valid <= NUM_REQ'(1) << r_gnt;
                    end else if (resp_ready[r_gnt]) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op_code = r_alu_op;
    assign alu_en      = r_alu_en;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a registered one-cycle ALU model (ALU_LAT=1).
module tb_alu_req_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [19:0]  req_op;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [63:0]  resp_data;
    logic         resp_err;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [4:0]   alu_op_code;
    logic         alu_en;
    logic [63:0]  alu_out = '0;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;

    alu_req_arbiter #(.NUM_REQ(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
        .alu_en(alu_en), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'b00001: alu_f = 64'(a) + 64'(b);
            5'b00010: alu_f = 64'(a) - 64'(b);
            5'b00011: alu_f = 64'(a) * 64'(b);
            5'b00100: alu_f = 64'(a) << 1;
            5'b00101: alu_f = 64'(a) >> 1;
            5'b00110: alu_f = 64'(a & b);
            5'b00111: alu_f = 64'(a | b);
            5'b01000: alu_f = 64'(a) + 64'd1;
            5'b01010: alu_f = 64'(a) - 64'd1;
            default:  alu_f = 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_en) begin
            alu_out <= alu_f(alu_op_code, alu_a, alu_b);
            en_cnt  <= en_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int en0;
        logic [3:0] exp_g;

        // 1. reset with all requesters valid
        rst        = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 4'b0000;
        req_a      = '0;
        req_b      = '0;
        req_op     = {4{5'b00001}};
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_alu_en", 64'(alu_en), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_alu_regs", {alu_a, 27'd0, alu_op_code}, 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_first_grant", 64'(req_ready), 64'b0001);
        req_valid = 4'b0000;

        // 2. single add on requester 1
        @(negedge clk);
        req_a[63:32]  = 32'd5;
        req_b[63:32]  = 32'd7;
        req_op[9:5]   = 5'b00001;
        req_valid     = 4'b0010;
        #1;
        chk("add_ready", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("add_alu_en", 64'(alu_en), 64'd1);
        chk("add_alu_ops", {alu_a, alu_b}, {32'd5, 32'd7});
        chk("add_alu_op", 64'(alu_op_code), 64'b00001);
        chk("add_no_resp_e0", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("add_no_resp_e1", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("add_resp_valid", 64'(resp_valid), 64'b0010);
        chk("add_resp_data", resp_data, 64'd12);
        chk("add_resp_err", 64'(resp_err), 64'd0);
        chk("add_alu_en_off", 64'(alu_en), 64'd0);
        resp_ready = 4'b0010;
        @(negedge clk);
        resp_ready = 4'b0000;
        chk("add_resp_done", 64'(resp_valid), 64'd0);
        chk("add_data_hold", resp_data, 64'd12);

        // 3. round robin from a fresh pointer, all requesters multiply 3*4
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'd3;
            req_b[32*i +: 32] = 32'd4;
            req_op[5*i +: 5]  = 5'b00011;
        end
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << (t % 4);
            n = 0;
            #1;
            while (req_ready == 4'b0000 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rr_grant", 64'(req_ready), 64'(exp_g));
            n = 0;
            @(negedge clk);
            while (resp_valid == 4'b0000 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_resp_valid", 64'(resp_valid), 64'(exp_g));
            chk("rr_resp_data", resp_data, 64'd12);
            @(negedge clk);
        end
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;

        // 4. illegal op on requester 2
        @(negedge clk);
        req_op[14:10] = 5'b01001;
        req_a[95:64]  = 32'd99;
        req_valid     = 4'b0100;
        en0           = en_cnt;
        #1;
        chk("ill_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("ill_no_resp_e0", 64'(resp_valid), 64'd0);
        chk("ill_alu_en", 64'(alu_en), 64'd0);
        @(negedge clk);
        chk("ill_resp_valid", 64'(resp_valid), 64'b0100);
        chk("ill_resp_err", 64'(resp_err), 64'd1);
        chk("ill_resp_data", resp_data, 64'd0);
        chk("ill_alu_untouched", {alu_a, 27'd0, alu_op_code}, {32'd3, 32'b00011});
        resp_ready = 4'b0100;
        @(negedge clk);
        resp_ready = 4'b0000;
        chk("ill_resp_done", 64'(resp_valid), 64'd0);
        chk("ill_no_alu_en_cycles", 64'(en_cnt - en0), 64'd0);

        // 5. backpressure on requester 0 while requester 1 waits
        req_a[31:0]  = 32'd10;
        req_b[31:0]  = 32'd3;
        req_op[4:0]  = 5'b00010;
        req_valid    = 4'b0011;
        #1;
        chk("bp_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        resp_ready = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", 64'(resp_valid), 64'b0001);
            chk("bp_hold_data", resp_data, 64'd7);
            chk("bp_no_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 4'b0001;
        @(negedge clk);
        resp_ready = 4'b0000;
        chk("bp_resp_done", 64'(resp_valid), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'b0010);
        req_valid = 4'b0000;
        #1;
        chk("drop_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("drop_no_exec", 64'(alu_en), 64'd0);
        chk("drop_alu_hold", 64'(alu_a), 64'd10);

        // 6. reset while an operation is executing
        req_a[63:32] = 32'd1;
        req_b[63:32] = 32'd1;
        req_op[9:5]  = 5'b00001;
        req_valid    = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        chk("mid_alu_en", 64'(alu_en), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_alu_en", 64'(alu_en), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("mid_no_resp", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        req_valid = 4'b1111;
        #1;
        chk("mid_ptr_reset", 64'(req_ready), 64'b0001);
        req_valid = 4'b0000;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
